// File: rtl/zprize_mul_share_arb.sv
// Round-robin arbiter sharing one pipelined wide multiplier among N requesters,
// steering tagged results back and capping per-requester outstanding ops.
// Optional statistics counters: define ZPRIZE_MUL_ARB_STAT_EN.
module zprize_mul_share_arb #(
  parameter int N       = 4,
  parameter int W       = 384,
  parameter int TW      = 8,
  parameter int MAX_OUT = 16,
  localparam int IDW    = $clog2(N),
  localparam int M      = 1 + IDW + TW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*W-1:0]    req_a,
  input  logic [N*W-1:0]    req_b,
  input  logic [N*TW-1:0]   req_tag,
  output logic [W-1:0]      mul_in0,
  output logic [W-1:0]      mul_in1,
  output logic [M-1:0]      mul_m_i,
  input  logic [M-1:0]      mul_m_o,
  input  logic [2*W-1:0]    mul_out,
  output logic [N-1:0]      res_valid,
  output logic [2*W-1:0]    res_data,
  output logic [TW-1:0]     res_tag,
`ifdef ZPRIZE_MUL_ARB_STAT_EN
  output logic [31:0]       stat_issue,
  output logic [31:0]       stat_stall,
`endif
  output logic              idle
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic [IDW-1:0] rr;
  logic [CW-1:0]  cnt [N];

  logic [N-1:0]   elig;
  logic [N-1:0]   grant;
  logic           grant_any;
  logic [IDW-1:0] grant_id;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic [TW-1:0]  sel_tag;

  logic           ret_vld;
  logic [IDW-1:0] ret_id;
  logic [TW-1:0]  ret_tag;
  logic [N-1:0]   ret_hot;
  logic           ret_ok;
  logic           cnt_all_zero;

  assign ret_vld = mul_m_o[M-1];
  assign ret_id  = mul_m_o[TW +: IDW];
  assign ret_tag = mul_m_o[TW-1:0];

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path can leave a value held and infer a latch.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++)
      elig[i] = rst & req_valid[i] & (cnt[i] < CW'(MAX_OUT));
  end

  // First eligible requester at or after the pointer, wrapping N-1 -> 0.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    for (int j = 0; j < N; j++) begin
      if (grant == '0 && elig[(int'(rr) + j) % N]) begin
        grant[(int'(rr) + j) % N] = 1'b1;
        grant_id                  = IDW'((int'(rr) + j) % N);
      end
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_tag = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_a   = req_a[i*W +: W];
        sel_b   = req_b[i*W +: W];
        sel_tag = req_tag[i*TW +: TW];
      end
    end
  end

  // A return only counts if its id is in range and that requester has work out;
  // this also swallows stale results that drain out after a reset.
  always_comb begin
    ret_hot = '0;
    for (int i = 0; i < N; i++)
      if (ret_vld && ret_id == IDW'(i) && cnt[i] != '0)
        ret_hot[i] = 1'b1;
  end

  always_comb begin
    cnt_all_zero = 1'b1;
    for (int i = 0; i < N; i++)
      if (cnt[i] != '0) cnt_all_zero = 1'b0;
  end

  assign ret_ok    = |ret_hot;
  assign grant_any = |grant;
  assign req_ready = grant;
  assign idle      = cnt_all_zero & ~grant_any & ~mul_m_i[M-1] & ~(|res_valid);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr        <= '0;
      mul_in0   <= '0;
      mul_in1   <= '0;
      mul_m_i   <= '0;
      res_valid <= '0;
      res_data  <= '0;
      res_tag   <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      if (grant_any) begin
        mul_in0 <= sel_a;
        mul_in1 <= sel_b;
        mul_m_i <= {1'b1, grant_id, sel_tag};
        rr      <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
      end else begin
        mul_m_i[M-1] <= 1'b0;
      end

      res_valid <= ret_hot;
      if (ret_ok) begin
        res_data <= mul_out;
        res_tag  <= ret_tag;
      end

      for (int i = 0; i < N; i++) begin
        case ({grant[i], ret_hot[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

`ifdef ZPRIZE_MUL_ARB_STAT_EN
  // A cycle with requests but no grant can only be blocked by the outstanding cap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_issue <= '0;
      stat_stall <= '0;
    end else begin
      if (grant_any && stat_issue != '1)
        stat_issue <= stat_issue + 32'd1;
      if (|req_valid && !grant_any && stat_stall != '1)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_zprize_mul_share_arb.sv
// Randomized bench for zprize_mul_share_arb: a latency-5 multiplier model with
// a return-withholding mode, and a scoreboard built from the arbitration rules.
module tb_zprize_mul_share_arb;

  localparam int N       = 4;
  localparam int W       = 384;
  localparam int TW      = 8;
  localparam int MAX_OUT = 16;
  localparam int IDW     = 2;
  localparam int M       = 1 + IDW + TW;
  localparam int LAT     = 5;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*W-1:0]    req_a;
  logic [N*W-1:0]    req_b;
  logic [N*TW-1:0]   req_tag;
  logic [W-1:0]      mul_in0;
  logic [W-1:0]      mul_in1;
  logic [M-1:0]      mul_m_i;
  logic [M-1:0]      mul_m_o;
  logic [2*W-1:0]    mul_out;
  logic [N-1:0]      res_valid;
  logic [2*W-1:0]    res_data;
  logic [TW-1:0]     res_tag;
  logic              idle;
`ifdef ZPRIZE_MUL_ARB_STAT_EN
  logic [31:0]       stat_issue;
  logic [31:0]       stat_stall;
`endif

  zprize_mul_share_arb #(.N(N), .W(W), .TW(TW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .mul_in0(mul_in0), .mul_in1(mul_in1), .mul_m_i(mul_m_i),
    .mul_m_o(mul_m_o), .mul_out(mul_out),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
`ifdef ZPRIZE_MUL_ARB_STAT_EN
    .stat_issue(stat_issue), .stat_stall(stat_stall),
`endif
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model; while hold is set, results are parked and only released on demand.
  logic [M-1:0]   st_m [LAT];
  logic [2*W-1:0] st_p [LAT];
  logic [M-1:0]   park_m [$];
  logic [2*W-1:0] park_p [$];
  bit             hold;
  bit             inj_v;
  logic [M-1:0]   inj_m;
  logic [2*W-1:0] inj_p;

  always @(posedge clk) begin
    st_m[0] <= mul_m_i;
    st_p[0] <= (2*W)'(mul_in0) * (2*W)'(mul_in1);
    for (int k = 1; k < LAT; k++) begin
      st_m[k] <= st_m[k-1];
      st_p[k] <= st_p[k-1];
    end
    if (hold && st_m[LAT-1][M-1] === 1'b1) begin
      park_m.push_back(st_m[LAT-1]);
      park_p.push_back(st_p[LAT-1]);
    end
  end

  assign mul_m_o = hold ? (inj_v ? inj_m : '0) : st_m[LAT-1];
  assign mul_out = hold ? (inj_v ? inj_p : '0) : st_p[LAT-1];

  // Reference model state.
  typedef struct {
    int             id;
    logic [2*W-1:0] p;
    logic [TW-1:0]  tag;
    int             cyc;
    bit             timed;
  } op_t;

  op_t            inflight [$];
  int             ref_cnt [N];
  int             ref_rr;
  bit             iss_pend;
  logic [M-1:0]   iss_m;
  logic [W-1:0]   iss_a;
  logic [W-1:0]   iss_b;
  bit             res_pend;
  op_t            res_op;
  int             ref_issue;
  int             ref_stall;
  int             cyc;
  bit             lat_phase;
  int             total;
  int             bad;

  task automatic check(input string tag, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) ref_cnt[i] = 0;
    ref_rr    = 0;
    iss_pend  = 0;
    res_pend  = 0;
    ref_issue = 0;
    ref_stall = 0;
    inflight.delete();
  endtask

  // One clock cycle: drive at negedge, check 1 ns later, then advance the model.
  task automatic step(input logic rst_v, input logic [N-1:0] v, input bit rel);
    int             g;
    int             id;
    int             fi;
    bit             idle_exp;
    logic [N-1:0]   exp_ready;
    logic [N-1:0]   exp_rv;
    op_t            op;
    @(negedge clk);
    rst       = rst_v;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W]     = rand_w();
      req_b[i*W +: W]     = rand_w();
      req_tag[i*TW +: TW] = TW'($urandom);
    end
    if (rel && park_m.size() > 0) begin
      inj_v = 1'b1;
      inj_m = park_m.pop_front();
      inj_p = park_p.pop_front();
    end else begin
      inj_v = 1'b0;
    end
    #1;

    g = -1;
    if (rst_v)
      for (int j = 0; j < N; j++)
        if (g < 0 && v[(ref_rr + j) % N] && ref_cnt[(ref_rr + j) % N] < MAX_OUT)
          g = (ref_rr + j) % N;
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    check("req_ready", req_ready, exp_ready);

    if (iss_pend) begin
      check("mul_m_i", mul_m_i, iss_m);
      check("mul_in0", mul_in0, iss_a);
      check("mul_in1", mul_in1, iss_b);
    end else begin
      check("mul_vld", mul_m_i[M-1], 1'b0);
    end

    exp_rv = res_pend ? N'(1 << res_op.id) : '0;
    check("res_valid", res_valid, exp_rv);
    if (res_pend) begin
      check("res_data", res_data, res_op.p);
      check("res_tag", res_tag, res_op.tag);
      if (res_op.timed) check("latency", cyc - res_op.cyc, 7);
    end

    idle_exp = (g < 0) && !iss_pend && !res_pend;
    for (int i = 0; i < N; i++) if (ref_cnt[i] != 0) idle_exp = 0;
    check("idle", idle, idle_exp);

    if (!rst_v) begin
      model_reset();
    end else begin
      res_pend = 0;
      if (mul_m_o[M-1] === 1'b1) begin
        id = int'(mul_m_o[TW +: IDW]);
        if (id < N && ref_cnt[id] > 0) begin
          fi = -1;
          for (int q = 0; q < inflight.size(); q++)
            if (fi < 0 && inflight[q].id == id) fi = q;
          if (fi >= 0) begin
            res_op = inflight[fi];
            inflight.delete(fi);
            res_pend = 1;
          end
          ref_cnt[id]--;
        end
      end
      iss_pend = 0;
      if (g >= 0) begin
        ref_cnt[g]++;
        ref_rr    = (g + 1) % N;
        iss_pend  = 1;
        iss_a     = req_a[g*W +: W];
        iss_b     = req_b[g*W +: W];
        iss_m     = {1'b1, IDW'(g), req_tag[g*TW +: TW]};
        op.id     = g;
        op.p      = (2*W)'(iss_a) * (2*W)'(iss_b);
        op.tag    = req_tag[g*TW +: TW];
        op.cyc    = cyc;
        op.timed  = lat_phase;
        inflight.push_back(op);
        ref_issue++;
      end else if (|v) begin
        ref_stall++;
      end
    end
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           n_g2;
    logic [N-1:0] seq [3];
    total     = 0;
    bad       = 0;
    cyc       = 0;
    hold      = 0;
    inj_v     = 0;
    inj_m     = '0;
    inj_p     = '0;
    lat_phase = 0;
    rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    model_reset();

    // Reset long enough for the multiplier model to flush.
    for (int k = 0; k < 8; k++) step(1'b0, '0, 0);
    check("rst_in0", mul_in0, '0);
    check("rst_in1", mul_in1, '0);
    check("rst_res_data", res_data, '0);
    check("rst_res_tag", res_tag, '0);
    check("rst_m_i", mul_m_i, '0);

    // All requesters valid: strict rotation and fixed 7-cycle return latency.
    lat_phase = 1;
    for (int k = 0; k < 40; k++) step(1'b1, 4'b1111, 0);
    lat_phase = 0;
    for (int k = 0; k < 10; k++) step(1'b1, '0, 0);

    // Random request patterns.
    for (int k = 0; k < 300; k++) step(1'b1, N'($urandom_range(0, 15)), 0);
    for (int k = 0; k < 10; k++) step(1'b1, '0, 0);

    // Reset mid-stream with several operations in flight.
    for (int k = 0; k < 5; k++) step(1'b1, 4'b1111, 0);
    step(1'b0, 4'b1111, 0);
    step(1'b0, 4'b1111, 0);
    check("rst_mid_ready", req_ready, '0);
    check("rst_mid_vld", mul_m_i[M-1], 1'b0);
    check("rst_mid_idle", idle, 1'b1);
    for (int k = 0; k < 12; k++) step(1'b1, '0, 0);

    // Outstanding cap on requester 2 with returns withheld.
    hold = 1;
    n_g2 = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 4'b0100, 0);
      if (req_ready[2]) n_g2++;
    end
    check("cap_grants", n_g2, 16);
    step(1'b1, 4'b0100, 1);
    if (req_ready[2]) n_g2++;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'b0100, 0);
      if (req_ready[2]) n_g2++;
    end
    check("cap_one_more", n_g2, 17);
    for (int k = 0; k < 6; k++) step(1'b1, 4'b0111, 0);
    for (int k = 0; k < 60; k++) step(1'b1, '0, 1);
    hold = 0;
    for (int k = 0; k < 8; k++) step(1'b1, '0, 0);

    // Pointer wrap: move rr to 3, then alternate 0 and 2.
    step(1'b1, 4'b0100, 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'b0101, 0);
      seq[k] = req_ready;
    end
    check("wrap_0", seq[0], 4'b0001);
    check("wrap_1", seq[1], 4'b0100);
    check("wrap_2", seq[2], 4'b0001);
    for (int k = 0; k < 12; k++) step(1'b1, '0, 0);

`ifdef ZPRIZE_MUL_ARB_STAT_EN
    check("stat_issue", stat_issue, ref_issue);
    check("stat_stall", stat_stall, ref_stall);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
